// File: rtl/mem_access_unit.sv
// Load/store sequencer between the execute stage and the 32 x 8 data memory.
// It runs one request at a time, pulses memRead/memWrite for one cycle, and returns data plus an error flag.
module mem_access_unit #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MEM_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t state;

    // The limit is one bit wider than the address so that MEM_DEPTH == 2**ADDR_W does not wrap to zero.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

    logic addr_ok;
    assign addr_ok   = ({1'b0, req_addr} < DEPTH_LIM);
    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            err_count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (!addr_ok) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            resp_valid <= 1'b1;
                            if (err_count != '1) begin
                                err_count <= err_count + 8'd1;
                            end
                            state <= RESP;
                        end else begin
                            mem_address <= req_addr;
                            if (req_we) begin
                                mem_write_data <= req_wdata;
                                mem_write      <= 1'b1;
                                state          <= WRITE;
                            end else begin
                                mem_read <= 1'b1;
                                state    <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    mem_read   <= 1'b0;
                    resp_rdata <= mem_read_data;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                WRITE: begin
                    mem_write  <= 1'b0;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory strobes are single-cycle and mutually exclusive, and a pending response must stay stable.
    a_strobe_excl: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));
    a_read_pulse:  assert property (@(posedge clk) disable iff (rst) mem_read |=> !mem_read);
    a_write_pulse: assert property (@(posedge clk) disable iff (rst) mem_write |=> !mem_write);
    a_resp_hold:   assert property (@(posedge clk) disable iff (rst)
                       (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_rdata) && $stable(resp_err)));

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. It contains a behavioural memory and a timeline model of the request lifecycle.
module tb_mem_access_unit;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_read_data;
    logic [7:0]        err_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_address   (mem_address),
        .mem_write_data(mem_write_data),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_read_data (mem_read_data),
        .err_count     (err_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Power-on contents: word i holds i below 16, and holds 16-i (mod 256) from 16 upward.
    function automatic logic [7:0] init_val(input int i);
        return (i < 16) ? 8'(i) : 8'(16 - i);
    endfunction

    logic [7:0] bmem [MEM_DEPTH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) bmem[i] <= init_val(i);
        end else if (mem_write) begin
            bmem[mem_address[4:0]] <= mem_write_data;
        end
    end

    assign mem_read_data = mem_read ? bmem[mem_address[4:0]] : '0;

    // The model tracks each accepted request by age: age 1 is the first cycle after the accept edge.
    bit         m_busy;
    int         m_age;
    logic       m_we;
    logic       m_err;
    logic [7:0] m_rdata;
    logic [7:0] m_last_addr;
    logic [7:0] m_last_wdata;
    logic [7:0] m_err_cnt;
    logic [7:0] ref_mem [MEM_DEPTH];

    function automatic int resp_lat(input logic err);
        return err ? 1 : 2;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy       = 0;
            m_age        = 0;
            m_we         = 1'b0;
            m_err        = 1'b0;
            m_rdata      = '0;
            m_last_addr  = '0;
            m_last_wdata = '0;
            m_err_cnt    = '0;
            for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = init_val(i);
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy = 1;
                m_age  = 1;
                m_we   = req_we;
                m_err  = (int'(req_addr) >= MEM_DEPTH);
                m_rdata = '0;
                if (m_err) begin
                    if (m_err_cnt < 8'd255) m_err_cnt++;
                end else begin
                    m_last_addr = req_addr;
                    if (req_we) begin
                        m_last_wdata = req_wdata;
                        ref_mem[req_addr[4:0]] = req_wdata;
                    end else begin
                        m_rdata = ref_mem[req_addr[4:0]];
                    end
                end
            end
        end else begin
            if (m_age >= resp_lat(m_err) && resp_ready) m_busy = 0;
            else m_age++;
        end
    end

    always @(negedge clk) begin
        logic e_valid;
        logic e_rd;
        logic e_wr;
        e_valid = m_busy && (m_age >= resp_lat(m_err));
        e_rd    = m_busy && (m_age == 1) && !m_err && !m_we;
        e_wr    = m_busy && (m_age == 1) && !m_err && m_we;
        chk("cmp_req_ready",  32'(req_ready),      32'(!m_busy));
        chk("cmp_resp_valid", 32'(resp_valid),     32'(e_valid));
        chk("cmp_mem_read",   32'(mem_read),       32'(e_rd));
        chk("cmp_mem_write",  32'(mem_write),      32'(e_wr));
        chk("cmp_mem_addr",   32'(mem_address),    32'(m_last_addr));
        chk("cmp_mem_wdata",  32'(mem_write_data), 32'(m_last_wdata));
        chk("cmp_err_count",  32'(err_count),      32'(m_err_cnt));
        if (e_valid) begin
            chk("cmp_resp_rdata", 32'(resp_rdata), 32'(m_rdata));
            chk("cmp_resp_err",   32'(resp_err),   32'(m_err));
        end
    end

    // The caller is away from a clock edge. The task returns 1 time unit after the accept edge.
    task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wd);
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                @(posedge clk);
                #1 req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("accept_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string name, input logic [7:0] exp_rd, input logic exp_err, input int exp_lat);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                chk({name, "_lat"},   32'(i),          32'(exp_lat));
                chk({name, "_rdata"}, 32'(resp_rdata), 32'(exp_rd));
                chk({name, "_err"},   32'(resp_err),   32'(exp_err));
                return;
            end
        end
        chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready",  32'(req_ready),   32'd1);
        chk("rst_resp_valid", 32'(resp_valid),  32'd0);
        chk("rst_mem_read",   32'(mem_read),    32'd0);
        chk("rst_mem_write",  32'(mem_write),   32'd0);
        chk("rst_err_count",  32'(err_count),   32'd0);
        chk("rst_mem_addr",   32'(mem_address), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_req(1'b0, 8'd5, 8'h00);
        chk("load5_memread", 32'(mem_read), 32'd1);
        wait_resp("load5", 8'h05, 1'b0, 2);

        @(negedge clk);
        do_req(1'b1, 8'd17, 8'hA5);
        chk("st17_memwrite", 32'(mem_write),      32'd1);
        chk("st17_wdata",    32'(mem_write_data), 32'hA5);
        chk("st17_addr",     32'(mem_address),    32'd17);
        wait_resp("st17", 8'h00, 1'b0, 2);
        do_req(1'b0, 8'd17, 8'h00);
        wait_resp("load17", 8'hA5, 1'b0, 2);
        do_req(1'b0, 8'd18, 8'h00);
        wait_resp("load18", 8'hFE, 1'b0, 2);

        do_req(1'b0, 8'd40, 8'h00);
        chk("err40_memread", 32'(mem_read), 32'd0);
        wait_resp("err40", 8'h00, 1'b1, 1);
        chk("err40_count", 32'(err_count), 32'd1);
        for (int i = 0; i < 299; i++) begin
            do_req(1'b0, 8'(32 + (i % 224)), 8'h00);
            wait_resp("err_loop", 8'h00, 1'b1, 1);
        end
        @(negedge clk);
        chk("err_saturate", 32'(err_count), 32'd255);

        // The second request is held while the first response is backpressured.
        resp_ready = 1'b0;
        do_req(1'b0, 8'd3, 8'h00);
        req_we    = 1'b0;
        req_addr  = 8'd4;
        req_valid = 1'b1;
        wait_resp("bp3", 8'h03, 1'b0, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(resp_valid), 32'd1);
            chk("bp_hold_rdata", 32'(resp_rdata), 32'h03);
            chk("bp_hold_ready", 32'(req_ready),  32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_idle_ready", 32'(req_ready),  32'd1);
        chk("bp_idle_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("bp_second_accepted", 32'(req_ready), 32'd0);
        wait_resp("bp4", 8'h04, 1'b0, 2);

        do_req(1'b0, 8'd1, 8'h00);
        wait_resp("b2b1", 8'h01, 1'b0, 2);
        chk("b2b_read_low", 32'(mem_read), 32'd0);
        do_req(1'b0, 8'd31, 8'h00);
        chk("b2b_read_high", 32'(mem_read), 32'd1);
        wait_resp("b2b31", 8'hF1, 1'b0, 2);

        @(negedge clk);
        do_req(1'b1, 8'd2, 8'h55);
        chk("rstmid_memwrite", 32'(mem_write), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid_write_low", 32'(mem_write),  32'd0);
        chk("rstmid_read_low",  32'(mem_read),   32'd0);
        chk("rstmid_no_resp",   32'(resp_valid), 32'd0);
        chk("rstmid_idle",      32'(req_ready),  32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid_quiet", 32'(resp_valid), 32'd0);
        end
        do_req(1'b0, 8'd2, 8'h00);
        wait_resp("load2_after_rst", 8'h02, 1'b0, 2);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
